pipe_add_n: RTL and testbench

PIPE_ADD_N -- requirements
Module: pipe_add_n

---
 rtl/pipe_add_n.sv | 103 ++++++++++
 tb/tb_pipe_add_n.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_add_n.sv
// Segmented carry-pipelined adder/subtractor: SEG bits per stage, latency WIDTH/SEG cycles.
// One global advance enable; the whole pipe freezes while a result waits on out_ready.
module pipe_add_n #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int STAGES = WIDTH / SEG;
  localparam int LAST   = STAGES - 1;

  logic [STAGES-1:0]            vld_q, vld_d, cy_q, cy_d, sub_q, sub_d;
  logic [STAGES-1:0][WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;

  // Per-stage operands: stage 0 reads the ports, stage k reads stage k-1's registers.
  logic [STAGES-1:0]            src_vld, src_cy, src_sub;
  logic [STAGES-1:0][WIDTH-1:0] src_a, src_b, src_res;

  logic adv_en;

  assign adv_en   = !vld_q[LAST] || out_ready;
  assign in_ready = adv_en;

  always_comb begin
    src_vld[0] = in_valid;
    src_sub[0] = sub;
    src_cy[0]  = c_in ^ sub;
    src_a[0]   = a;
    src_b[0]   = sub ? ~b : b;
    src_res[0] = '0;
    for (int k = 1; k < STAGES; k++) begin
      src_vld[k] = vld_q[k-1];
      src_sub[k] = sub_q[k-1];
      src_cy[k]  = cy_q[k-1];
      src_a[k]   = a_q[k-1];
      src_b[k]   = b_q[k-1];
      src_res[k] = res_q[k-1];
    end
  end

  always_comb begin
    logic [SEG:0] seg_sum;
    vld_d   = vld_q;
    cy_d    = cy_q;
    sub_d   = sub_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    seg_sum = '0;
    if (adv_en) begin
      for (int k = 0; k < STAGES; k++) begin
        seg_sum  = {1'b0, src_a[k][k*SEG +: SEG]} + {1'b0, src_b[k][k*SEG +: SEG]}
                 + {{SEG{1'b0}}, src_cy[k]};
        vld_d[k] = src_vld[k];
        cy_d[k]  = seg_sum[SEG];
        sub_d[k] = src_sub[k];
        a_d[k]   = src_a[k];
        b_d[k]   = src_b[k];
        res_d[k] = src_res[k];
        res_d[k][k*SEG +: SEG] = seg_sum[SEG-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      cy_q  <= '0;
      sub_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
    end else begin
      vld_q <= vld_d;
      cy_q  <= cy_d;
      sub_q <= sub_d;
      a_q   <= a_d;
      b_q   <= b_d;
      res_q <= res_d;
    end
  end

  // b_q already holds the effective (inverted for subtract) operand, so one sign rule serves both modes.
  assign out_valid = vld_q[LAST];
  assign sum       = res_q[LAST];
  assign c_out     = cy_q[LAST] ^ sub_q[LAST];
  assign ovf       = (a_q[LAST][WIDTH-1] == b_q[LAST][WIDTH-1]) &&
                     (res_q[LAST][WIDTH-1] != a_q[LAST][WIDTH-1]);

endmodule

// File: tb/tb_pipe_add_n.sv
// Bench for pipe_add_n: directed and random ops against an arithmetic reference with a stall-aware timing model.
module tb_pipe_add_n;

  localparam int W      = 16;
  localparam int SEG    = 4;
  localparam int STAGES = W / SEG;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] a, b;
  logic         c_in, sub, in_valid, in_ready;
  logic [W-1:0] sum;
  logic         c_out, ovf, out_valid, out_ready;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           adv;
  } exp_t;

  exp_t exp_q[$];
  int   adv_cnt  = 0;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  pipe_add_n #(.WIDTH(W), .SEG(SEG)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .sub       (sub),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum       (sum),
    .c_out     (c_out),
    .ovf       (ovf),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // Plain integer arithmetic: unsigned result for sum/carry/borrow, signed result for overflow.
  function automatic exp_t ref_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                                  input logic ci, input logic sb);
    exp_t e;
    int ua, ub, sa, sbs, ur, sr;
    ua  = int'(av);
    ub  = int'(bv);
    sa  = int'($signed(av));
    sbs = int'($signed(bv));
    if (sb) begin
      ur     = ua - ub - int'(ci);
      sr     = sa - sbs - int'(ci);
      e.cout = (ur < 0);
    end else begin
      ur     = ua + ub + int'(ci);
      sr     = sa + sbs + int'(ci);
      e.cout = (ur >= (1 << W));
    end
    e.sum = ur[W-1:0];
    e.ovf = (sr > ((1 << (W-1)) - 1)) || (sr < -(1 << (W-1)));
    e.adv = 0;
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  // One clock cycle, entered and left at a falling edge. An op is due once the
  // pipe has advanced STAGES times since it was accepted.
  task automatic cycle(input logic iv, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic ci, input logic sb, input logic ordy, output logic took);
    logic exp_v, exp_en;
    exp_t e;
    exp_v = (exp_q.size() > 0) && (adv_cnt - exp_q[0].adv >= STAGES);
    check("out_valid", {31'd0, out_valid}, {31'd0, exp_v});
    if (exp_v) begin
      check("sum",   {16'd0, sum},   {16'd0, exp_q[0].sum});
      check("c_out", {31'd0, c_out}, {31'd0, exp_q[0].cout});
      check("ovf",   {31'd0, ovf},   {31'd0, exp_q[0].ovf});
    end
    in_valid  = iv;
    a         = av;
    b         = bv;
    c_in      = ci;
    sub       = sb;
    out_ready = ordy;
    #1;
    exp_en = !exp_v || ordy;
    check("in_ready", {31'd0, in_ready}, {31'd0, exp_en});
    took = iv && exp_en;
    @(posedge clk);
    if (exp_v && ordy) void'(exp_q.pop_front());
    if (took) begin
      e     = ref_op(av, bv, ci, sb);
      e.adv = adv_cnt;
      exp_q.push_back(e);
    end
    if (exp_en) adv_cnt++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    logic t;
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, t);
  endtask

  initial begin
    logic         t;
    logic [W-1:0] ra, rb;
    logic         rc, rs, pend;
    int           left;

    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; sub = 1'b0; out_ready = 1'b1;
    ra = '0; rb = '0; rc = 1'b0; rs = 1'b0; pend = 1'b0; left = 0;
    #2;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_sum",       {16'd0, sum},       32'd0);
    check("rst_c_out",     {31'd0, c_out},     32'd0);
    check("rst_ovf",       {31'd0, ovf},       32'd0);
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed corner cases: small add, full wrap, signed overflow both modes.
    cycle(1'b1, 16'h0003, 16'h0005, 1'b0, 1'b0, 1'b1, t);
    cycle(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, t);
    cycle(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, t);
    cycle(1'b1, 16'h0005, 16'h0007, 1'b0, 1'b1, 1'b1, t);
    cycle(1'b1, 16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1, t);
    cycle(1'b1, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b1, t);
    cycle(1'b1, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b1, t);
    idle(STAGES + 2);

    // Back-to-back random ops with mixed modes, no backpressure.
    for (int i = 0; i < 8; i++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom); rs = 1'($urandom);
      cycle(1'b1, ra, rb, rc, rs, 1'b1, t);
    end
    idle(STAGES + 2);

    // Three-cycle downstream stall mid-stream; ops are held until accepted.
    left = 6;
    pend = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!pend && left > 0) begin
        ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom); rs = 1'($urandom);
        pend = 1'b1;
      end
      cycle(pend, ra, rb, rc, rs, !(i >= 5 && i < 8), t);
      if (t) begin
        pend = 1'b0;
        left--;
      end
    end
    check("stall_ops_sent", left, 0);

    // Bubbles and random backpressure together.
    pend = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!pend && ($urandom_range(0, 2) != 0)) begin
        ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom); rs = 1'($urandom);
        pend = 1'b1;
      end
      cycle(pend, ra, rb, rc, rs, 1'($urandom_range(0, 3) != 0), t);
      if (t) pend = 1'b0;
    end
    idle(STAGES + 4);
    check("drained", exp_q.size(), 0);

    // Reset with a result on the output and three ops behind it.
    for (int i = 0; i < 4; i++) begin
      ra = W'($urandom); rb = W'($urandom);
      cycle(1'b1, ra, rb, 1'b0, 1'b0, 1'b1, t);
    end
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check("arst_sum",       {16'd0, sum},       32'd0);
    check("arst_c_out",     {31'd0, c_out},     32'd0);
    check("arst_ovf",       {31'd0, ovf},       32'd0);
    check("arst_in_ready",  {31'd0, in_ready},  32'd1);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    idle(STAGES + 4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
